// File: rtl/x7seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan interface:
// segment pattern table (active-low, bit6=a .. bit0=g), digit count,
// blanked-anode constant, receiver FSM states and small helpers.
package x7seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    // Active-low segment patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // True when a blanked position sits below a shown one; leading-zero
    // blanking may only remove a contiguous run at the top.
    function automatic logic blank_rule_bad(input logic [NUM_DIGITS-1:0] seen);
        logic bad;
        logic shown_above;
        bad = 1'b0;
        shown_above = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (seen[i])
                shown_above = 1'b1;
            else if (shown_above)
                bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/x7seg_seg2hex.sv
// Combinational segment-pattern to hex-nibble decoder. Unknown patterns
// decode to 0 with inv raised.
module x7seg_seg2hex
    import x7seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       inv
);

    logic [15:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign hit[gi] = (seg == SEG_TABLE[gi]);
        end
    endgenerate

    // Patterns in the table are distinct, so at most one hit is set
    always_comb begin
        nib = 4'd0;
        inv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                nib = 4'(i);
                inv = 1'b0;
            end
        end
    end

endmodule

// File: rtl/x7seg_rx.sv
// Receiver for a 4-digit multiplexed 7-segment scan. Filters scan
// transitions, captures one nibble per accepted slot and publishes the
// reconstructed value at each digit-0 frame boundary.
// Optional macro X7SEG_RX_SYNC_EN inserts a 2-flop input synchronizer
// (reset to all-ones) ahead of the sampler, adding 2 cycles of latency.
module x7seg_rx
    import x7seg_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic        CP,
    input  logic        CR,
    input  logic [6:0]  a_to_g,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] x,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        err,
    output logic        lost
);

    // Stable counter must be able to hold STABLE_CYC itself
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYC);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC - 1);

    logic [3:0] an_in;
    logic [6:0] seg_in;
    logic       dp_unused;

`ifdef X7SEG_RX_SYNC_EN
    logic [11:0] sync1_reg;
    logic [11:0] sync2_reg;

    // Two-flop synchronizer; idles at blank so no slot is seen at startup
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= {dp, an, a_to_g};
            sync2_reg <= sync1_reg;
        end
    end

    assign dp_unused = sync2_reg[11];
    assign an_in     = sync2_reg[10:7];
    assign seg_in    = sync2_reg[6:0];
`else
    assign dp_unused = dp;
    assign an_in     = an;
    assign seg_in    = a_to_g;
`endif

    // ---------------- sampler / glitch filter ----------------
    logic [10:0]   samp_reg;
    logic [10:0]   samp_next;
    logic [SW-1:0] stab_reg;
    logic [SW-1:0] stab_next;
    logic          changed;
    logic          accept_reg;
    logic          accept_next;

    assign samp_next = {an_in, seg_in};
    assign changed   = (samp_next != samp_reg);

    // Run-length of identical samples; accept fires once when it reaches STABLE_CYC
    always_comb begin
        stab_next = stab_reg;
        if (changed)
            stab_next = SW'(1);
        else if (stab_reg != STABLE_MAX)
            stab_next = stab_reg + 1'b1;
        accept_next = (stab_next == STABLE_MAX)
                   && (changed || (stab_reg != STABLE_MAX))
                   && $onehot(~an_in);
    end

    // Sample register, stable counter and accept strobe
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            samp_reg   <= '0;
            stab_reg   <= '0;
            accept_reg <= 1'b0;
        end else begin
            samp_reg   <= samp_next;
            stab_reg   <= stab_next;
            accept_reg <= accept_next;
        end
    end

    // ---------------- slot decode ----------------
    logic [1:0] slot;
    logic [3:0] dec_nib;
    logic       dec_inv;

    // Position of the single low anode in the accepted sample
    always_comb begin
        slot = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!samp_reg[7 + i])
                slot = 2'(i);
        end
    end

    x7seg_seg2hex u_seg2hex (
        .seg (samp_reg[6:0]),
        .nib (dec_nib),
        .inv (dec_inv)
    );

    // ---------------- capture FSM ----------------
    state_t        state_reg, state_next;
    logic [3:0]    nib_reg  [NUM_DIGITS];
    logic [3:0]    nib_next [NUM_DIGITS];
    logic [3:0]    seen_reg, seen_next;
    logic          ferr_reg, ferr_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic          lost_reg, lost_next;
    logic [15:0]   x_reg, x_next;
    logic [3:0]    blank_reg, blank_next;
    logic          err_reg, err_next;
    logic          valid_reg, valid_next;
    logic          acc0;

    assign acc0 = accept_reg && (slot == 2'd0);

    // Next-state: slot capture, frame publish at digit 0, timeout (accept wins)
    always_comb begin
        state_next = state_reg;
        nib_next   = nib_reg;
        seen_next  = seen_reg;
        ferr_next  = ferr_reg;
        tcnt_next  = tcnt_reg;
        lost_next  = lost_reg;
        x_next     = x_reg;
        blank_next = blank_reg;
        err_next   = err_reg;
        valid_next = 1'b0;

        if (acc0)
            tcnt_next = '0;
        else if (tcnt_reg != TIMEOUT_MAX)
            tcnt_next = tcnt_reg + 1'b1;

        if (accept_reg) begin
            if (slot == 2'd0) begin
                lost_next = 1'b0;
                if (state_reg == COLLECT) begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        x_next[i*4 +: 4] = seen_reg[i] ? nib_reg[i] : 4'd0;
                    blank_next = ~seen_reg;
                    err_next   = ferr_reg | blank_rule_bad(seen_reg);
                    valid_next = 1'b1;
                end
                state_next  = COLLECT;
                nib_next[0] = dec_nib;
                seen_next   = 4'b0001;
                ferr_next   = dec_inv;
            end else if (state_reg == COLLECT) begin
                nib_next[slot]  = dec_nib;
                seen_next[slot] = 1'b1;
                ferr_next       = ferr_reg | dec_inv;
            end
        end else if (tcnt_reg == TIMEOUT_MAX) begin
            lost_next  = 1'b1;
            state_next = IDLE;
            seen_next  = 4'b0000;
            ferr_next  = 1'b0;
        end
    end

    // FSM, capture and output registers
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_reg <= IDLE;
            for (int i = 0; i < NUM_DIGITS; i++)
                nib_reg[i] <= 4'd0;
            seen_reg  <= 4'b0000;
            ferr_reg  <= 1'b0;
            tcnt_reg  <= '0;
            lost_reg  <= 1'b0;
            x_reg     <= 16'h0000;
            blank_reg <= 4'b1110;
            err_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            nib_reg   <= nib_next;
            seen_reg  <= seen_next;
            ferr_reg  <= ferr_next;
            tcnt_reg  <= tcnt_next;
            lost_reg  <= lost_next;
            x_reg     <= x_next;
            blank_reg <= blank_next;
            err_reg   <= err_next;
            valid_reg <= valid_next;
        end
    end

    assign x     = x_reg;
    assign blank = blank_reg;
    assign err   = err_reg;
    assign valid = valid_reg;
    assign lost  = lost_reg;

endmodule

// File: tb/tb_x7seg_rx.sv
// Self-checking bench for x7seg_rx: directed scans from the test plan plus
// randomized frames, compared against a slot-level reference model.
module tb_x7seg_rx;

    localparam int STABLE = 4;
    localparam int TMO    = 512;
`ifdef X7SEG_RX_SYNC_EN
    localparam int LAT = STABLE + 3;
`else
    localparam int LAT = STABLE + 1;
`endif
    localparam logic [6:0] SEG_OFF    = 7'b1111111;
    localparam logic [6:0] SEG_GLITCH = 7'b1110111;

    localparam logic [6:0] SEGS [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        CP = 1'b0;
    logic        CR = 1'b0;
    logic [6:0]  a_to_g = 7'b1111111;
    logic [3:0]  an = 4'b1111;
    logic        dp = 1'b1;
    logic [15:0] x;
    logic [3:0]  blank;
    logic        valid;
    logic        err;
    logic        lost;

    x7seg_rx #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
        .CP(CP), .CR(CR), .a_to_g(a_to_g), .an(an), .dp(dp),
        .x(x), .blank(blank), .valid(valid), .err(err), .lost(lost)
    );

    always #5 CP = ~CP;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge CP) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model (slot level) ----------------
    typedef struct {
        logic [15:0] x;
        logic [3:0]  blank;
        logic        err;
        int          at;
    } pub_t;

    pub_t        expq[$];
    bit          m_collect = 0;
    logic [3:0]  m_seen = 4'b0000;
    logic [3:0]  m_nib [4];
    bit          m_ferr = 0;
    logic [15:0] m_x = 16'h0000;
    logic [3:0]  m_blank = 4'b1110;
    bit          m_err = 0;

    function automatic void decode(input logic [6:0] s, output logic [3:0] n, output bit ok);
        n = 4'd0;
        ok = 0;
        for (int i = 0; i < 16; i++)
            if (SEGS[i] == s) begin
                n = 4'(i);
                ok = 1;
            end
    endfunction

    task automatic model_accept(input int k, input logic [6:0] s, input int at);
        logic [3:0]  n;
        bit          ok;
        logic [15:0] nx;
        pub_t        p;
        decode(s, n, ok);
        if (k == 0) begin
            if (m_collect) begin
                nx = 16'h0000;
                for (int i = 0; i < 4; i++)
                    if (m_seen[i]) nx = nx + (16'(m_nib[i]) << (4 * i));
                p.x     = nx;
                p.blank = ~m_seen;
                p.err   = m_ferr || !(p.blank == 4'b0000 || p.blank == 4'b1000 ||
                                      p.blank == 4'b1100 || p.blank == 4'b1110);
                p.at    = at + LAT;
                expq.push_back(p);
                m_x = p.x;
                m_blank = p.blank;
                m_err = p.err;
            end
            m_collect = 1;
            m_seen = 4'b0001;
            m_nib[0] = n;
            m_ferr = !ok;
        end else if (m_collect) begin
            m_nib[k] = n;
            m_seen[k] = 1'b1;
            m_ferr = m_ferr || !ok;
        end
    endtask

    // Apply one slot for 'hold' clock edges; accepted if long enough and one-hot
    task automatic drive_slot(input logic [3:0] a, input logic [6:0] s, input int hold);
        int k;
        logic [3:0] na;
        @(negedge CP);
        an = a;
        a_to_g = s;
        na = ~a;
        if (hold >= STABLE && $countones(na) == 1) begin
            k = 0;
            for (int i = 0; i < 4; i++)
                if (na[i]) k = i;
            model_accept(k, s, cyc);
        end
        repeat (hold - 1) @(negedge CP);
    endtask

    // One scan frame, digit 0 first; positions with show=0 are blanked slots
    task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                        input logic [6:0] s0, input logic [3:0] show, input int hold);
        logic [6:0] segs [4];
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int k = 0; k < 4; k++) begin
            if (show[k])
                drive_slot(~(4'b0001 << k), segs[k], hold);
            else
                drive_slot(4'b1111, SEG_OFF, hold);
        end
    endtask

    // Publication monitor
    always @(negedge CP) begin : mon
        pub_t p;
        if (CR && valid) begin
            if (expq.size() == 0) begin
                check("valid_unexpected", 1, 0);
            end else begin
                p = expq.pop_front();
                check("x", x, p.x);
                check("blank", blank, p.blank);
                check("err", err, p.err);
                check("latency", cyc, p.at);
                check("lost_at_valid", lost, 0);
            end
        end
    end

    initial begin
        int r;
        int hold;
        logic [3:0] ga;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'd0;

        // Reset state
        repeat (3) @(negedge CP);
        check("rst_x", x, 16'h0000);
        check("rst_blank", blank, 4'b1110);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_lost", lost, 0);
        CR = 1'b1;

        // 0x0000 with only digit 0 shown, 3 frames
        repeat (3) scan(SEG_OFF, SEG_OFF, SEG_OFF, SEGS[0], 4'b0001, 8);
        // 0x1A3F, all shown
        repeat (2) scan(SEGS[1], SEGS[10], SEGS[3], SEGS[15], 4'b1111, 8);
        drive_slot(4'b1110, SEGS[15], 8);
        check("dir_x_1a3f", x, 16'h1A3F);
        check("dir_blank_1a3f", blank, 4'b0000);
        check("dir_err_1a3f", err, 0);
        drive_slot(4'b1101, SEGS[3], 8);
        drive_slot(4'b1011, SEGS[10], 8);
        drive_slot(4'b0111, SEGS[1], 8);
        // Invalid pattern on digit 1, then clean frames
        scan(SEGS[1], SEGS[10], SEG_OFF, SEGS[15], 4'b1111, 8);
        repeat (2) scan(SEGS[1], SEGS[10], SEGS[3], SEGS[15], 4'b1111, 8);
        // Blank-rule violation: digit 1 blanked under shown digits
        scan(SEGS[7], SEGS[5], SEG_OFF, SEGS[2], 4'b1101, 8);
        scan(SEGS[7], SEGS[5], SEGS[4], SEGS[2], 4'b1111, 8);
        // 2-cycle glitch between slots
        drive_slot(4'b1101, SEG_GLITCH, 2);
        scan(SEGS[7], SEGS[5], SEGS[4], SEGS[2], 4'b1111, 8);
        drive_slot(4'b1110, SEGS[2], 8);
        check("dir_x_glitch", x, 16'h7542);

        // Scan stops: signal loss, outputs hold
        m_collect = 0;
        drive_slot(4'b1111, SEG_OFF, TMO + 20);
        check("lost_set", lost, 1);
        check("lost_x_hold", x, m_x);
        check("lost_blank_hold", blank, m_blank);
        check("lost_err_hold", err, m_err);
        scan(SEG_OFF, SEG_OFF, SEGS[9], SEGS[8], 4'b0011, 8);
        check("lost_clear", lost, 0);

        // Randomized frames
        for (int f = 0; f < 120; f++) begin
            for (int k = 1; k < 4; k++) begin
                r = $urandom_range(0, 9);
                hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 9);
                if (r < 2)
                    drive_slot(4'b1111, SEG_OFF, hold);
                else if (r == 2)
                    drive_slot(~(4'b0001 << k), SEG_OFF, hold);
                else if (r == 3)
                    drive_slot(~(4'b0001 << k) & 4'b1110, SEGS[$urandom_range(0, 15)], hold);
                else
                    drive_slot(~(4'b0001 << k), SEGS[$urandom_range(0, 15)], hold);
            end
            if ($urandom_range(0, 3) == 0) begin
                ga = ~(4'b0001 << $urandom_range(1, 3));
                drive_slot(ga, SEG_GLITCH, $urandom_range(1, 3));
            end
            if ($urandom_range(0, 9) == 0)
                drive_slot(4'b1110, SEG_OFF, $urandom_range(4, 9));
            else
                drive_slot(4'b1110, SEGS[$urandom_range(0, 15)], $urandom_range(4, 9));
        end

        // Reset mid-frame discards partial data
        scan(SEGS[3], SEGS[2], SEGS[1], SEGS[6], 4'b1111, 8);
        drive_slot(4'b1110, SEGS[6], 8);
        drive_slot(4'b1101, SEGS[1], 8);
        check("pre_reset_pending", expq.size(), 0);
        @(negedge CP);
        an = 4'b1011;
        a_to_g = SEGS[2];
        repeat (2) @(negedge CP);
        CR = 1'b0;
        #1;
        check("mid_rst_x", x, 16'h0000);
        check("mid_rst_blank", blank, 4'b1110);
        check("mid_rst_valid", valid, 0);
        m_collect = 0;
        m_x = 16'h0000;
        m_blank = 4'b1110;
        m_err = 0;
        repeat (3) @(negedge CP);
        an = 4'b1111;
        a_to_g = SEG_OFF;
        CR = 1'b1;
        scan(SEGS[12], SEGS[11], SEGS[13], SEGS[14], 4'b1111, 8);
        check("post_rst_x", x, 16'h0000);
        check("post_rst_blank", blank, 4'b1110);
        scan(SEG_OFF, SEG_OFF, SEG_OFF, SEGS[5], 4'b0001, 8);
        check("post_rst_x2", x, 16'hCBDE);

        repeat (LAT + 10) @(negedge CP);
        check("pending_valid", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
